vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces 640x480@60 Hz VGA raster timing from a 25 MHz pixel clock.
- Drives x/y coordinates to pixel-generating game blocks and samples their 1-bit pixel reply.
- Emits hsync/vsync and a blank-masked video bit, delayed so they align with the pixel reply.
- Generates frame_tick, used as the per-frame enable for game-state update logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_LATENCY, 1, clocks from x/y presented to pixel_in valid (range 1..4)

Ports:
- clk  in  1  pixel clock, 25 MHz (50 MHz with CLK_DIV2_EN)
- rst_n  in  1  synchronous active-low reset
- pixel_in  in  1  pixel reply from game logic, valid PIX_LATENCY clocks after x/y
- x  out  10  current horizontal count
- y  out  9  current vertical count, low 9 bits
- active  out  1  high while h_count<H_ACTIVE and v_count<V_ACTIVE; undelayed, qualifies x/y
- hsync  out  1  active-low horizontal sync, pipeline-aligned
- vsync  out  1  active-low vertical sync, pipeline-aligned
- video_out  out  1  pixel_in AND delayed active
- frame_tick  out  1  one-clock pulse at start of vertical blank

Behaviour:
- Counters:
  - Internal h_count 0..H_TOTAL-1 (H_TOTAL=800) and v_count 0..V_TOTAL-1 (V_TOTAL=525), both 10 bits.
  - h_count increments every pixel step.
  - At H_TOTAL-1, h_count wraps to 0 and v_count increments.
  - v_count wraps to 0 after V_TOTAL-1 when h_count also wraps.
  - Frame = 420000 pixel steps.
- x = h_count. y = v_count[8:0].
  - Outside the active region x/y are truncated raw counts, not clamped. Consumers must qualify with active.
- Raw sync, combinational from counters:
  - hsync_raw = 0 for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vsync_raw = 0 for v_count in [490,491], across the whole line including h_count 0..799.
- Alignment:
  - hsync_raw, vsync_raw and active pass through a PIX_LATENCY-deep register pipeline.
  - The final stage is registered: hsync/vsync are registered outputs, and video_out is registered from pixel_in & active_pipe.
  - So the pixel reply for (x,y) and its sync/blank appear on outputs together, PIX_LATENCY+1 clocks after x/y.
- frame_tick:
  - High for exactly one clock when h_count==0 and v_count==V_ACTIVE (480).
  - Registered, so it asserts the clock after that count state.
  - Exactly one pulse per frame.
- Reset:
  - h_count=0, v_count=0, so x=0, y=0, active=1 combinationally.
  - hsync=1, vsync=1, video_out=0, frame_tick=0.
  - All pipeline stages load inactive values: sync 1, active 0.
- Reset mid-frame: the next clock after rst_n deasserts counts from (0,0); no partial sync pulse is emitted from the pipeline.
- pixel_in is ignored whenever delayed active=0; video_out is forced 0 in blanking.

Optional Feature:
- Macro: CLK_DIV2_EN.
- Defined:
  - clk is 50 MHz. An internal toggle flop (reset 0) produces pix_ce, high every second clock, first high on the second clock after reset.
  - Counters, pipeline stages, video_out and frame_tick advance only when pix_ce=1; outputs hold otherwise.
  - frame_tick is one clk wide, asserted on the pix_ce clock.
  - PIX_LATENCY is counted in pixel steps.
- Undefined: pix_ce is tied to 1; every clock is a pixel step.

Decomposition:
- Package vga_pkg:
  - Default 640x480 timing constants.
  - Derived H_TOTAL/V_TOTAL and sync start/end localparams.
  - Counter width constant (10).
- Sub-module sync_delay_line:
  - Parameterized width/depth shift register with synchronous reset value and clock-enable.
  - Instantiated once, 3 bits wide (hsync, vsync, active), depth PIX_LATENCY.

Test Plan:
- Reset 5 clocks, release -> hsync=1, vsync=1, video_out=0, frame_tick=0 during reset; x=0,y=0 first clock after release; x=1 next.
- Run one line -> x wraps 799->0 and y increments; hsync low exactly 96 clocks, falling PIX_LATENCY+1 clocks after x=656.
- Run two full frames -> vsync low 1600 clocks per frame; frame_tick pulses once per 420000 clocks, at x=0,y=480 +1 clock.
- Drive pixel_in=1 constantly -> video_out high exactly 640 clocks per visible line, 307200 per frame, 0 in blanking; with PIX_LATENCY=3, first high 4 clocks after x=0,y=0.
- Assert rst_n=0 at x=700,y=491 (mid-vsync) -> vsync returns 1 during reset, and after release timing restarts from (0,0) with no glitch pulses.
- With CLK_DIV2_EN -> x advances every second clk; line = 1600 clks; frame_tick one clk wide once per 840000 clks.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants and helpers for vga_timing_gen
//
// Purpose:
//   Default 640x480@60 Hz VGA timing values and the totals and sync windows
//   derived from them. Also holds the counter width, the packed bundle of
//   per-pixel sync/blank bits, and a small window-compare helper.
//   The top-level module takes these values as parameter defaults, so a
//   different mode can be built without editing this file.
//
// Ports: none (package).

`default_nettype none

package vga_pkg;

  // Both raster counters are 10 bits wide: 0..799 and 0..524.
  localparam int CNT_W = 10;

  // Default 640x480@60 horizontal timing, in pixel clocks.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default 640x480@60 vertical timing, in lines.
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // The game logic answers one clock after x/y by default.
  localparam int DEF_PIX_LATENCY = 1;

  // Derived totals: 800 clocks per line, 525 lines per frame.
  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Inclusive sync windows: hsync 656..751, vsync 490..491.
  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

  // Per-pixel timing bits that travel down the alignment pipeline.
  typedef struct packed {
    logic hsync;   // active-low
    logic vsync;   // active-low
    logic active;  // visible region
  } sync_bits_t;

  // Value a pipeline stage holds while idle: both syncs released, blanked.
  localparam sync_bits_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

  // True when cnt lies in the inclusive window [lo, hi].
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay_line.sv
// rtl/vga_timing_gen_sync_delay_line.sv - clock-enabled shift register with synchronous reset value
//
// Purpose:
//   DEPTH-stage, WIDTH-bit shift register. Every stage loads RESET_VAL while
//   rst_n is low and shifts by one stage on each clock where ce is high.
//   vga_timing_gen uses it to delay the raw sync/blank bits by the game
//   logic's pixel latency.
//
// Ports:
//   clk    in  1      clock
//   rst_n  in  1      synchronous active-low reset, loads RESET_VAL everywhere
//   ce     in  1      shift enable
//   din    in  WIDTH  value entering stage 0
//   dout   out WIDTH  value leaving stage DEPTH-1

`default_nettype none

module sync_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Flush every stage so no stale or partial sync pulse can drain out
      // after a reset that arrives mid-frame.
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else if (ce) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing generator with pixel-reply alignment
//
// Purpose:
//   Runs the horizontal/vertical raster counters and presents x/y to the
//   pixel-generating game blocks. Their 1-bit reply is sampled, and
//   hsync/vsync/blank are delayed so that the reply and its timing leave on
//   the outputs together, PIX_LATENCY+1 pixel steps after x/y. Also
//   produces frame_tick, a one-clock pulse at the start of vertical blank,
//   which the game-state update logic uses as its per-frame enable.
//
// Build option:
//   CLK_DIV2_EN  When defined, clk is 50 MHz and an internal toggle makes a
//                pixel step every second clock. When undefined, every clock
//                is a pixel step.
//
// Ports:
//   clk         in  1   pixel clock (25 MHz; 50 MHz with CLK_DIV2_EN)
//   rst_n       in  1   synchronous active-low reset
//   pixel_in    in  1   game pixel reply, valid PIX_LATENCY steps after x/y
//   x           out 10  horizontal count (raw, qualify with active)
//   y           out 9   vertical count, low 9 bits (raw, qualify with active)
//   active      out 1   visible region, undelayed, qualifies x/y
//   hsync       out 1   active-low horizontal sync, aligned with video_out
//   vsync       out 1   active-low vertical sync, aligned with video_out
//   video_out   out 1   pixel_in masked by delayed active
//   frame_tick  out 1   one-clock pulse after count (0, V_ACTIVE)

`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int PIX_LATENCY = DEF_PIX_LATENCY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixel_in,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       video_out,
  output logic       frame_tick
);

  // Count values the raster logic compares against, at counter width.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             pix_ce;
  sync_bits_t       raw_bits;
  sync_bits_t       dly_bits;

  // ---------------------------------------------------------------------
  // Pixel-step enable
  // ---------------------------------------------------------------------
`ifdef CLK_DIV2_EN
  // The toggle resets to 0, so the first pixel step falls on the second
  // clock after reset and every second clock after that.
  logic ce_toggle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_toggle <= 1'b0;
    end else begin
      ce_toggle <= ~ce_toggle;
    end
  end

  assign pix_ce = ce_toggle;
`else
  assign pix_ce = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_ce) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        if (v_count == V_LAST) begin
          v_count <= '0;
        end else begin
          v_count <= v_count + CNT_W'(1);
        end
      end else begin
        h_count <= h_count + CNT_W'(1);
      end
    end
  end

  // x/y are the raw counts; outside the visible area they are not clamped.
  assign x      = h_count;
  assign y      = v_count[8:0];
  assign active = (h_count < H_VIS) && (v_count < V_VIS);

  // The counter MSB only matters internally; y carries the low 9 bits.
  logic unused_v_msb;
  assign unused_v_msb = v_count[CNT_W-1];

  // ---------------------------------------------------------------------
  // Raw timing bits, then delay to match the game logic's reply latency
  // ---------------------------------------------------------------------
  // vsync_raw depends only on v_count, so it covers whole lines.
  assign raw_bits.hsync  = ~in_window(h_count, HS_START, HS_END);
  assign raw_bits.vsync  = ~in_window(v_count, VS_START, VS_END);
  assign raw_bits.active = active;

  sync_delay_line #(
    .WIDTH     ($bits(sync_bits_t)),
    .DEPTH     (PIX_LATENCY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (pix_ce),
    .din   (raw_bits),
    .dout  (dly_bits)
  );

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  // A pixel reply arrives together with its delayed timing bits; one more
  // register puts the reply and its sync/blank on the pins in the same
  // clock. The reply is discarded in blanking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      video_out <= 1'b0;
    end else if (pix_ce) begin
      hsync     <= dly_bits.hsync;
      vsync     <= dly_bits.vsync;
      video_out <= pixel_in & dly_bits.active;
    end
  end

  // frame_tick is reloaded on every clock, not just on pixel steps. That
  // keeps it one clk wide even when pixel steps are two clocks apart.
  // It fires once per frame: on the step that leaves (0, V_ACTIVE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_ce && (h_count == '0) && (v_count == V_VIS);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard testbench for vga_timing_gen on a reduced raster

`timescale 1ns/1ps

module tb_vga_timing_gen;

  localparam int H_ACTIVE = 40;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 6;
  localparam int V_ACTIVE = 20;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int PL       = 3;

  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 58
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 27
  localparam int FRAME    = HT * VT;                           // 1566
  localparam int HS_START = H_ACTIVE + H_FP;                   // 44
  localparam int HS_END   = HS_START + H_SYNC - 1;             // 51
  localparam int VS_START = V_ACTIVE + V_FP;                   // 22
  localparam int VS_END   = VS_START + V_SYNC - 1;             // 23
`ifdef CLK_DIV2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pixel_in = 1'b0;
  logic [9:0] x;
  logic [8:0] y;
  logic       active, hsync, vsync, video_out, frame_tick;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_LATENCY(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .x(x), .y(y),
    .active(active), .hsync(hsync), .vsync(vsync), .video_out(video_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       vid;
    logic       ft;
  } obs_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
  } out_t;

  int   passed = 0;
  int   total = 0;
  out_t sb_q[$];
  bit   game_q[$];
  int   mh, mv;
  bit   mce, exp_ft, pix_const;
  out_t held;

  function automatic bit hraw(int h);
    return !(h >= HS_START && h <= HS_END);
  endfunction

  function automatic bit vraw(int v);
    return !(v >= VS_START && v <= VS_END);
  endfunction

  function automatic bit act_of(int h, int v);
    return (h < H_ACTIVE) && (v < V_ACTIVE);
  endfunction

  function automatic bit pat(int h, int v);
    if (pix_const) return 1'b1;
    return bit'((h ^ v ^ (h >> 2)) & 1);
  endfunction

  function automatic obs_t obs();
    return {x, y, active, hsync, vsync, video_out, frame_tick};
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("x=%0d y=%0d act=%b hs=%b vs=%b vid=%b ft=%b",
                     v.x, v.y, v.act, v.hs, v.vs, v.vid, v.ft);
  endfunction

  // Called right after releasing reset: the next negedge is step 0 at (0,0).
  // Outputs for the first PL+1 steps still come from the reset values.
  task automatic model_reset();
    mh = 0;
    mv = 0;
    exp_ft = 1'b0;
    mce = (S == 1);
    sb_q.delete();
    game_q.delete();
    for (int i = 0; i < PL + 1; i++) sb_q.push_back('{hs: 1'b1, vs: 1'b1, vid: 1'b0});
  endtask

  // Moves one clock forward, plays the game logic (reply PL steps after
  // x/y), and returns what the DUT must show in this clock.
  task automatic advance(output obs_t e);
    bit first;
    bit a;
    @(negedge clk);
    first = (S == 1) || !mce;
    if (first) begin
      a = act_of(mh, mv);
      sb_q.push_back('{hs: hraw(mh), vs: vraw(mv), vid: a & pat(mh, mv)});
      held = sb_q.pop_front();
      game_q.push_back(pat(mh, mv));
      if (game_q.size() > PL) pixel_in = game_q.pop_front();
      else pixel_in = 1'b1;
    end
    e.x   = 10'(mh);
    e.y   = 9'(mv);
    e.act = act_of(mh, mv);
    e.hs  = held.hs;
    e.vs  = held.vs;
    e.vid = held.vid;
    e.ft  = exp_ft;
    exp_ft = mce && (mh == 0) && (mv == V_ACTIVE);
    if (mce) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    if (S == 2) mce = !mce;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_n = 1'b0;
    pixel_in = 1'b1;
    pix_const = 1'b0;
    repeat (5) begin
      @(negedge clk);
      o = obs();
      total++;
      if (o !== obs_t'({10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}))
        $display("FAIL reset_state: got %s want x=0 y=0 act=1 hs=1 vs=1 vid=0 ft=0", fmt(o));
      else passed++;
    end
    release_reset();
    advance(e);
    o = obs();
    total++;
    if (o.x !== 10'd0 || o.y !== 9'd0)
      $display("FAIL reset_first_xy: got x=%0d y=%0d want x=0 y=0", o.x, o.y);
    else passed++;
    for (int i = 0; i < S; i++) begin
      advance(e);
      o = obs();
      total++;
      if (o !== e) $display("FAIL reset_sb: got %s want %s", fmt(o), fmt(e));
      else passed++;
    end
    total++;
    if (o.x !== 10'd1) $display("FAIL reset_x_next: got x=%0d want x=1", o.x);
    else passed++;
  endtask

  task automatic test_line();
    obs_t e, o;
    logic [9:0] px = 10'd1;
    logic [8:0] py = 9'd0;
    bit ph = 1'b1, fell = 1'b0;
    int n_hs = -100000, n_fall = 0;
    for (int n = 0; n < 3 * HT * S; n++) begin
      advance(e);
      o = obs();
      total++;
      if (o !== e) $display("FAIL line_sb: got %s want %s", fmt(o), fmt(e));
      else passed++;
      if (o.x == 10'(HS_START) && px != 10'(HS_START)) n_hs = n;
      if (px == 10'(HT - 1) && o.x == 10'd0) begin
        total++;
        if (o.y !== 9'(py + 1)) $display("FAIL line_wrap_y: got y=%0d want y=%0d", o.y, py + 1);
        else passed++;
      end
      if (ph && !o.hs) begin
        fell = 1'b1;
        n_fall = n;
        total++;
        if (n - n_hs !== (PL + 1) * S)
          $display("FAIL hsync_latency: got %0d clocks want %0d", n - n_hs, (PL + 1) * S);
        else passed++;
      end
      if (!ph && o.hs && fell) begin
        total++;
        if (n - n_fall !== H_SYNC * S)
          $display("FAIL hsync_width: got %0d clocks want %0d", n - n_fall, H_SYNC * S);
        else passed++;
      end
      px = o.x;
      py = o.y;
      ph = o.hs;
    end
  endtask

  task automatic test_frames();
    obs_t e, o, po;
    bit fell = 1'b0;
    int ticks = 0, n_tick = -1, n_vfall = 0;
    po = obs();
    for (int n = 0; n < 2 * FRAME * S; n++) begin
      advance(e);
      o = obs();
      total++;
      if (o !== e) $display("FAIL frames_sb: got %s want %s", fmt(o), fmt(e));
      else passed++;
      if (o.ft && !po.ft) begin
        ticks++;
        total++;
        if (po.x !== 10'd0 || po.y !== 9'(V_ACTIVE))
          $display("FAIL tick_position: got prior x=%0d y=%0d want x=0 y=%0d", po.x, po.y, V_ACTIVE);
        else passed++;
        if (n_tick >= 0) begin
          total++;
          if (n - n_tick !== FRAME * S)
            $display("FAIL tick_period: got %0d clocks want %0d", n - n_tick, FRAME * S);
          else passed++;
        end
        n_tick = n;
      end
      if (po.vs && !o.vs) begin
        fell = 1'b1;
        n_vfall = n;
      end
      if (!po.vs && o.vs && fell) begin
        total++;
        if (n - n_vfall !== V_SYNC * HT * S)
          $display("FAIL vsync_width: got %0d clocks want %0d", n - n_vfall, V_SYNC * HT * S);
        else passed++;
      end
      po = o;
    end
    total++;
    if (ticks !== 2) $display("FAIL tick_count: got %0d pulses want 2", ticks);
    else passed++;
  endtask

  task automatic test_video_const();
    obs_t e, o;
    bit pv = 1'b0, rose = 1'b0;
    int first_hi = -1, highs = 0, n_rise = 0;
    pix_const = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    for (int n = 0; n < (PL + 1) * S + FRAME * S; n++) begin
      advance(e);
      o = obs();
      total++;
      if (o !== e) $display("FAIL video_sb: got %s want %s", fmt(o), fmt(e));
      else passed++;
      if (o.vid && first_hi < 0) first_hi = n;
      if (o.vid && n >= (PL + 1) * S) highs++;
      if (o.vid && !pv) begin
        rose = 1'b1;
        n_rise = n;
      end
      if (!o.vid && pv && rose) begin
        total++;
        if (n - n_rise !== H_ACTIVE * S)
          $display("FAIL video_line_len: got %0d clocks want %0d", n - n_rise, H_ACTIVE * S);
        else passed++;
      end
      pv = o.vid;
    end
    total++;
    if (first_hi !== (PL + 1) * S)
      $display("FAIL video_first_high: got clock %0d want %0d", first_hi, (PL + 1) * S);
    else passed++;
    total++;
    if (highs !== H_ACTIVE * V_ACTIVE * S)
      $display("FAIL video_frame_count: got %0d want %0d", highs, H_ACTIVE * V_ACTIVE * S);
    else passed++;
    pix_const = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    obs_t e, o, po;
    bit found = 1'b0, hfell = 1'b0, vfell = 1'b0;
    int n_hf = 0, n_vf = 0;
    for (int i = 0; i < 2 * FRAME * S && !found; i++) begin
      advance(e);
      o = obs();
      total++;
      if (o !== e) $display("FAIL midrst_pre_sb: got %s want %s", fmt(o), fmt(e));
      else passed++;
      if (o.x == 10'(HS_START + 2) && o.y == 9'(VS_START + 1)) found = 1'b1;
    end
    total++;
    if (!found) $display("FAIL midrst_reach: got not reached want x=%0d y=%0d", HS_START + 2, VS_START + 1);
    else passed++;
    total++;
    if (vsync !== 1'b0) $display("FAIL midrst_in_vsync: got vsync=%b want 0", vsync);
    else passed++;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      o = obs();
      total++;
      if (o !== obs_t'({10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}))
        $display("FAIL midrst_hold: got %s want x=0 y=0 act=1 hs=1 vs=1 vid=0 ft=0", fmt(o));
      else passed++;
    end
    release_reset();
    po = obs();
    for (int n = 0; n < FRAME * S + HT * S; n++) begin
      advance(e);
      o = obs();
      total++;
      if (o !== e) $display("FAIL midrst_post_sb: got %s want %s", fmt(o), fmt(e));
      else passed++;
      if (po.hs && !o.hs) begin hfell = 1'b1; n_hf = n; end
      if (!po.hs && o.hs) begin
        total++;
        if (!hfell || n - n_hf !== H_SYNC * S)
          $display("FAIL midrst_hsync_glitch: got %0d clocks want %0d", n - n_hf, H_SYNC * S);
        else passed++;
      end
      if (po.vs && !o.vs) begin vfell = 1'b1; n_vf = n; end
      if (!po.vs && o.vs) begin
        total++;
        if (!vfell || n - n_vf !== V_SYNC * HT * S)
          $display("FAIL midrst_vsync_glitch: got %0d clocks want %0d", n - n_vf, V_SYNC * HT * S);
        else passed++;
      end
      po = o;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_video_const();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
